// File: rtl/exp_req_ctrl.sv
// Exception-request source controller: latches device edges and timer ticks, issues one
// prioritised request at a time to CP0, and tracks the in-service source until ERET.
module exp_req_ctrl #(
    parameter int unsigned NSRC        = 3,
    parameter int unsigned TIMER_W     = 16,
    parameter int unsigned ACK_TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NSRC-1:0]    dev_req_i,
    input  logic               exp_ack_i,
    input  logic               eret_i,
    input  logic               exp_block_i,
    input  logic               timer_load_i,
    input  logic [TIMER_W-1:0] timer_din_i,
    input  logic               timer_en_i,
    output logic [NSRC-1:0]    exp_src_o,
    output logic [NSRC-1:0]    pending_o,
    output logic [NSRC-1:0]    in_service_o,
    output logic               busy_o,
    output logic               ack_err_o,
    output logic [TIMER_W-1:0] timer_count_o
);

    localparam int unsigned TmoW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TmoW-1:0] TmoMax = TmoW'(ACK_TIMEOUT - 1);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StReq     = 2'd1;
    localparam logic [1:0] StService = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [NSRC-1:0]    dev_prev_q;
    logic               ack_prev_q;
    logic               block_q;
    logic [TIMER_W-1:0] count_q, count_d;
    logic [TIMER_W-1:0] reload_q, reload_d;
    logic [NSRC-1:0]    pending_q, pending_d;
    logic [NSRC-1:0]    sel_q, sel_d;
    logic [NSRC-1:0]    exp_src_q, exp_src_d;
    logic [NSRC-1:0]    in_service_q, in_service_d;
    logic               ack_err_q, ack_err_d;
    logic [TmoW-1:0]    tmo_q, tmo_d;

    logic               tick;
    logic               ack_rise;
    logic [NSRC-1:0]    rise;
    logic [NSRC-1:0]    clr;
    logic [NSRC-1:0]    first_pend;

    // Periodic interval timer: load beats decrement, reload on the 1 -> reload step.
    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        tick     = 1'b0;
        if (timer_load_i) begin
            reload_d = timer_din_i;
            count_d  = timer_din_i;
        end else if (timer_en_i && (count_q != '0)) begin
            if (count_q == TIMER_W'(1)) begin
                tick    = 1'b1;
                count_d = reload_q;
            end else begin
                count_d = count_q - TIMER_W'(1);
            end
        end
    end

    assign rise     = (dev_req_i & ~dev_prev_q) | NSRC'(tick);
    assign ack_rise = exp_ack_i & ~ack_prev_q;

    // Lowest index wins.
    always_comb begin
        first_pend = '0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                first_pend    = '0;
                first_pend[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        exp_src_d    = exp_src_q;
        in_service_d = in_service_q;
        ack_err_d    = ack_err_q;
        tmo_d        = tmo_q;
        clr          = '0;
        unique case (state_q)
            StIdle: begin
                // Block must have been low for a full cycle so a Status write has settled.
                if ((pending_q != '0) && !exp_block_i && !block_q) begin
                    state_d   = StReq;
                    sel_d     = first_pend;
                    exp_src_d = first_pend;
                    tmo_d     = '0;
                end
            end
            StReq: begin
                if (ack_rise) begin
                    state_d      = StService;
                    clr          = sel_q;
                    in_service_d = sel_q;
                    exp_src_d    = '0;
                end else if (exp_block_i) begin
                    state_d   = StIdle;
                    exp_src_d = '0;
                end else if (tmo_q == TmoMax) begin
                    state_d   = StIdle;
                    exp_src_d = '0;
                    ack_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StService: begin
                if (eret_i) begin
                    state_d      = StIdle;
                    in_service_d = '0;
                end
            end
            default: begin
                state_d      = StIdle;
                exp_src_d    = '0;
                in_service_d = '0;
            end
        endcase
    end

    // A new edge on a bit being cleared this cycle stays pending.
    assign pending_d = (pending_q & ~clr) | rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            dev_prev_q   <= '0;
            ack_prev_q   <= 1'b0;
            block_q      <= 1'b0;
            count_q      <= '0;
            reload_q     <= '0;
            pending_q    <= '0;
            sel_q        <= '0;
            exp_src_q    <= '0;
            in_service_q <= '0;
            ack_err_q    <= 1'b0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            dev_prev_q   <= dev_req_i;
            ack_prev_q   <= exp_ack_i;
            block_q      <= exp_block_i;
            count_q      <= count_d;
            reload_q     <= reload_d;
            pending_q    <= pending_d;
            sel_q        <= sel_d;
            exp_src_q    <= exp_src_d;
            in_service_q <= in_service_d;
            ack_err_q    <= ack_err_d;
            tmo_q        <= tmo_d;
        end
    end

    assign exp_src_o     = exp_src_q;
    assign pending_o     = pending_q;
    assign in_service_o  = in_service_q;
    assign busy_o        = (state_q != StIdle);
    assign ack_err_o     = ack_err_q;
    assign timer_count_o = count_q;

endmodule
